// File: rtl/key_debounce.sv
// Four-key debouncer for a 100 Hz scan clock: 2-flop synchronizer, per-key press/release FSM,
// registered level/pulse/code outputs. Define KEY_REPEAT_EN to build the held-key auto-repeat.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_PERIOD   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] swc,
  output logic [3:0] key_level,
  output logic [3:0] key_pulse,
  output logic [1:0] key_code,
  output logic       code_valid
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_param_check
    $error("key_debounce: all parameters must lie in 1..255");
  end

  logic [3:0] sync1, sync2, s;
  state_t     state_q [4];
  state_t     state_d [4];
  logic [7:0] cnt_q   [4];
  logic [7:0] cnt_d   [4];
  logic [3:0] level_d, pulse_d;
  logic [1:0] code_d;
  logic       valid_d;

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] RD = 8'(REPEAT_DELAY);
  localparam logic [7:0] RP = 8'(REPEAT_PERIOD);
  // rep_q: first repeat already emitted, so the timer now runs on REPEAT_PERIOD.
  logic [3:0] rep_q, rep_d;
`endif

  // Keys are released (high) out of reset, hence the synchronizer resets to ones.
  assign s = ~sync2;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_d = key_level;
    pulse_d = '0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
`endif
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = 8'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DB) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            pulse_d[i] = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = 8'd1;
          end else begin
`ifdef KEY_REPEAT_EN
            cnt_d[i] = cnt_q[i] + 8'd1;
            if ((!rep_q[i] && cnt_d[i] == RD) || (rep_q[i] && cnt_d[i] == RP)) begin
              pulse_d[i] = 1'b1;
              cnt_d[i]   = '0;
              rep_d[i]   = 1'b1;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          // A bounce back restarts the repeat timer from the delay phase, without a pulse.
          if (s[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
`ifdef KEY_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else if (cnt_q[i] >= DB) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end

    // Walk downwards so the lowest pulsing index is the one that sticks.
    code_d = key_code;
    for (int i = 3; i >= 0; i--) begin
      if (pulse_d[i]) code_d = 2'(i);
    end
    valid_d = code_valid | (|pulse_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '1;
      sync2      <= '1;
      key_level  <= '0;
      key_pulse  <= '0;
      key_code   <= '0;
      code_valid <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q      <= '0;
`endif
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so sync2 takes the old sync1.
      sync1      <= swc;
      sync2      <= sync1;
      key_level  <= level_d;
      key_pulse  <= pulse_d;
      key_code   <= code_d;
      code_valid <= valid_d;
`ifdef KEY_REPEAT_EN
      rep_q      <= rep_d;
`endif
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 2, the consecutive stable samples needed to accept a level change (range 1..255).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50, the cycles held before the first auto-repeat pulse (range 1..255).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10, the cycles between later auto-repeat pulses (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, the 100 Hz scan clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port swc, input, 4 bits: raw board keys, active-low, asynchronous to clk.
REQ-007 The block SHALL have port key_level, output, 4 bits: debounced pressed state, 1 = pressed.
REQ-008 The block SHALL have port key_pulse, output, 4 bits: one-cycle press event per key.
REQ-009 The block SHALL have port key_code, output, 2 bits: index of the most recently accepted pressed key.
REQ-010 The block SHALL have port code_valid, output, 1 bit: sticky flag, set by the first accepted press after reset.

Function
REQ-011 Each swc bit SHALL pass through a 2-flop synchronizer; the sampled level s = ~sync2.
REQ-012 Each key SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, and an 8-bit counter cnt.
REQ-013 In IDLE with s=1, the FSM SHALL go to PRESS_WAIT with cnt=1; with s=0 it SHALL stay in IDLE.
REQ-014 In PRESS_WAIT with s=1 and cnt reaching DEBOUNCE_CYCLES, the FSM SHALL go to PRESSED, set key_level and assert key_pulse for exactly one cycle; with s=0 it SHALL return to IDLE with cnt=0.
REQ-015 In PRESSED with s=0, the FSM SHALL go to RELEASE_WAIT with cnt=1.
REQ-016 In RELEASE_WAIT with s=0 for DEBOUNCE_CYCLES consecutive samples, the FSM SHALL go to IDLE and clear key_level with no pulse; with s=1 it SHALL return to PRESSED with no new pulse.
REQ-017 When DEBOUNCE_CYCLES=1, the transition out of PRESS_WAIT or RELEASE_WAIT SHALL occur on the first sample that enters that state's acceptance check.
REQ-018 Press latency SHALL be: key_pulse rises exactly 2+DEBOUNCE_CYCLES rising edges after the first edge at which swc is sampled low, and stays high for one cycle.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES samples SHALL produce no change on key_level or key_pulse.
REQ-020 On any cycle with key_pulse nonzero, key_code SHALL update on the same edge to the lowest pulsing index, and code_valid SHALL be set.
REQ-021 Simultaneous press events SHALL assert all affected key_pulse bits together.
REQ-022 Outputs SHALL be registered, with no combinational path from swc to any output.

Reset
REQ-023 When rst is asserted, sync flops SHALL be forced to 1 (released), all FSMs to IDLE, and all counters to 0.
REQ-024 When rst is asserted, key_level, key_pulse, key_code and code_valid SHALL all be 0.
REQ-025 A reset during PRESS_WAIT or PRESSED SHALL discard the press, and a key still held at deassertion SHALL be re-debounced from IDLE, producing one new pulse.

Configuration
REQ-026 With macro KEY_REPEAT_EN defined, a key in PRESSED SHALL emit a key_pulse after REPEAT_DELAY held cycles and then every REPEAT_PERIOD cycles until it leaves PRESSED; each repeat pulse SHALL update key_code as in REQ-020.
REQ-027 With KEY_REPEAT_EN undefined, no repeat logic SHALL be built, and exactly one key_pulse SHALL occur per accepted press.
REQ-028 In either configuration, a RELEASE_WAIT bounce back to PRESSED SHALL restart the repeat timer with no immediate pulse.

Verification
REQ-029 Scenario clean press: DEBOUNCE_CYCLES=2; swc[1] low from edge 0 held for 10 cycles -> key_pulse=4'b0010 at edge 4 only, key_level[1]=1 from edge 4, key_code=1, code_valid=1.
REQ-030 Scenario glitch reject: swc[2] low for 1 cycle, then high -> key_level and key_pulse stay 0 and code_valid stays 0.
REQ-031 Scenario simultaneous press: swc[3] and swc[0] go low on the same edge -> key_pulse=4'b1001 for one cycle and key_code=0.
REQ-032 Scenario release bounce: held key, swc high for 1 cycle then low again -> key_level stays 1 and no extra pulse occurs.
REQ-033 Scenario mid-press reset: rst pulsed while in PRESSED with the key still held -> outputs are 0 during reset, then one pulse 2+DEBOUNCE_CYCLES edges after rst falls.
REQ-034 Scenario repeat: KEY_REPEAT_EN defined, REPEAT_DELAY=5, REPEAT_PERIOD=3, key held for 20 cycles -> pulses at acceptance, +5, +8, +11, +14 and +17; without KEY_REPEAT_EN, only the acceptance pulse occurs.
